eeg_sample_streamer: RTL and testbench
======================================

Name: eeg_sample_streamer

Overview:
Producer side of the preprocessor sample interface: turns a byte stream into timed DATA_WIDTH-bit EEG samples for moving_average's data_in.
- Input: host link (UART RX byte stream), valid/ready handshake.
- Assembles little-endian bytes into samples and buffers them in a FIFO.
- Releases one sample every SAMPLE_PERIOD clocks, with prebuffering and underflow reporting.

Parameters:
DATA_WIDTH, 16, sample width; must be a multiple of 8 (NB = DATA_WIDTH/8 bytes per sample).
FIFO_DEPTH, 16, sample FIFO depth in words; must be a power of 2, at least 2.
PRIME_LEVEL, 8, FIFO level needed before streaming (re)starts; range 1..FIFO_DEPTH.
SAMPLE_PERIOD, 10, clocks between output samples; at least 2.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  reset, asynchronous, active-low.
byte_in  in  8  incoming byte.
byte_valid  in  1  byte_in is valid.
byte_ready  out  1  streamer accepts byte this cycle.
enable  in  1  streaming enable (level).
flush  in  1  one-cycle synchronous clear of buffered data.
data_out  out  DATA_WIDTH  sample to the filter (drives moving_average data_in).
data_valid  out  1  one-cycle strobe: data_out updated this cycle.
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
underflow  out  1  sticky: a sample tick found the FIFO empty.

Behaviour:
- Reset (rst=0, asynchronous): data_out=0, data_valid=0, byte_ready=0, fifo_level=0, underflow=0, byte counter=0, FSM=IDLE, tick counter=0.
- Byte assembly:
  - byte_ready = !fifo_full (registered state only; no combinational path from byte_valid).
  - A byte is accepted when byte_valid && byte_ready. Byte k (k = 0..NB-1) fills bits [8k+7:8k] of the assembly register.
  - On acceptance of byte NB-1, the assembled word is pushed into the FIFO in that same cycle and the byte counter wraps to 0.
- FIFO:
  - First-word fall-through, synchronous.
  - Push is never allowed when full, even if a pop occurs in the same cycle.
  - A pop on an empty FIFO has no bypass: a same-cycle push does not satisfy the pop.
  - fifo_level reflects both push and pop of a cycle in the next cycle.
- Output FSM:
  - IDLE: waits. Moves to PRIME when enable=1.
  - PRIME: moves to STREAM when fifo_level >= PRIME_LEVEL. Tick counter is loaded with SAMPLE_PERIOD-1 on the transition.
  - STREAM: tick counter increments each cycle. When it equals SAMPLE_PERIOD-1, it clears and a tick occurs.
    - Tick with FIFO non-empty: pop; next cycle data_out = popped word and data_valid = 1 for exactly one cycle.
    - Tick with FIFO empty: underflow <= 1, data_out holds its last value, no data_valid, FSM -> PRIME.
  - enable=0 in any state: FSM -> IDLE next cycle and tick counter clears. FIFO contents and data_out are retained.
- Timing: the first pop occurs on the first STREAM cycle; later pops follow every SAMPLE_PERIOD cycles. Latency from pop to data_valid is 1 cycle.
- flush (same cycle, any state):
  - Empties the FIFO, clears the byte counter and underflow.
  - FSM -> PRIME if enable=1, else IDLE.
  - Any byte or pop in the flush cycle is discarded. data_out is retained.
- Reset mid-operation: partial bytes and buffered words are lost; behaviour as in the reset bullet above.

Optional Feature:
EEG_OFFSET_BINARY_EN:
- Defined: the assembled word's MSB is inverted before the FIFO push, converting offset-binary ADC codes to two's complement.
- Undefined: words pass through unchanged.

Decomposition:
- preprocessor_pkg holds:
  - the shared DATA_WIDTH default constant;
  - typedef enum logic [1:0] {IDLE, PRIME, STREAM} streamer_state_t;
  - a sample_t typedef.
- One sub-module, sample_fifo: parameterised FWFT FIFO with push, pop, full, empty and level outputs.
- The assembler and FSM stay in the top module.

Test Plan:
- Basic streaming. PRIME_LEVEL=2, SAMPLE_PERIOD=10, enable=1. Send bytes 34,12,78,56 (hex).
  Required: data_out=0x1234 with a data_valid pulse, then 0x5678 exactly 10 cycles later; underflow then set on the next tick.
- Backpressure. enable=0, send 34 samples' worth of bytes.
  Required: fifo_level=16 and byte_ready=0; the held byte stalls until enable=1 and the first pop, after which byte_ready rises.
- Underflow hold. After the basic streaming case:
  Required: data_out stays 0x5678, underflow=1, FSM in PRIME, no further data_valid until 2 more samples arrive.
- Flush of a partial sample. Send AA, pulse flush, then send 01,00.
  Required: the sample delivered is 0x0001; fifo_level=0 right after flush; underflow cleared.
- Asynchronous reset mid-stream. Drop rst between clock edges.
  Required: data_out=0, data_valid=0, byte_ready=0, fifo_level=0 immediately, without waiting for a clock edge.
- With EEG_OFFSET_BINARY_EN defined:
  Required: input words 0x8000 -> 0x0000, 0x0000 -> 0x8000, 0xFFFF -> 0x7FFF.

Source files
------------

// File: rtl/preprocessor_pkg.sv
// Shared types and defaults for the EEG preprocessor sample path.
// Optional macro: EEG_OFFSET_BINARY_EN (offset-binary to two's complement).
package preprocessor_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } streamer_state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through sample FIFO with synchronous clear.
// Exposes the next-cycle level so producers can register their ready flag.
module sample_fifo
  import preprocessor_pkg::*;
#(
  parameter int W     = DEF_DATA_WIDTH,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] level_nxt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o      = (cnt_q == LW'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign level_o     = cnt_q;
  assign level_nxt_o = cnt_d;
  assign rdata_o     = mem_q[rptr_q];

  // Push is judged on the current level only: a same-cycle pop never frees room.
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop)
        cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push)
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/eeg_sample_streamer.sv
// Byte-to-sample assembler and paced sample streamer for the filter input.
// Optional macro: EEG_OFFSET_BINARY_EN inverts the sample MSB before buffering.
module eeg_sample_streamer
  import preprocessor_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = 16,
  parameter int PRIME_LEVEL   = 8,
  parameter int SAMPLE_PERIOD = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  input  logic                          enable,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] word_d;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  byte_ready_q;
  logic                  accept;
  logic                  push;

  streamer_state_t       state_q;
  logic [TW-1:0]         tick_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  underflow_q;
  logic                  tick;
  logic                  pop;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LW-1:0]         fifo_lvl;
  logic [LW-1:0]         fifo_lvl_nxt;

  assign byte_ready = byte_ready_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign fifo_level = fifo_lvl;
  assign underflow  = underflow_q;

  assign accept = byte_valid && byte_ready_q && !fifo_full && !flush;
  assign push   = accept && (cnt_q == LAST_BYTE);

  always_comb begin
    word_d = asm_q;
    for (int k = 0; k < NB; k++) begin
      if (cnt_q == CW'(k)) word_d[8*k +: 8] = byte_in;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush)
      cnt_d = '0;
    else if (accept)
      cnt_d = (cnt_q == LAST_BYTE) ? '0 : cnt_q + 1'b1;
  end

`ifdef EEG_OFFSET_BINARY_EN
  assign push_data = {~word_d[DATA_WIDTH-1], word_d[DATA_WIDTH-2:0]};
`else
  assign push_data = word_d;
`endif

  assign tick = (state_q == STREAM) && (tick_q == TICK_MAX)
             && enable && !flush;
  assign pop  = tick && !fifo_empty;

  sample_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (flush),
    .push_i      (push),
    .wdata_i     (push_data),
    .pop_i       (pop),
    .rdata_o     (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_lvl),
    .level_nxt_o (fifo_lvl_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      byte_ready_q <= (fifo_lvl_nxt != LW'(FIFO_DEPTH));
      if (accept) asm_q <= word_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (flush) begin
        state_q     <= enable ? PRIME : IDLE;
        tick_q      <= '0;
        underflow_q <= 1'b0;
      end else if (!enable) begin
        state_q <= IDLE;
        tick_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= PRIME;
          PRIME: begin
            // Preload so the first pop lands on the first STREAM cycle.
            if (fifo_lvl >= LW'(PRIME_LEVEL)) begin
              state_q <= STREAM;
              tick_q  <= TICK_MAX;
            end
          end
          STREAM: begin
            if (tick_q == TICK_MAX) begin
              tick_q <= '0;
              if (fifo_empty) begin
                underflow_q <= 1'b1;
                state_q     <= PRIME;
              end else begin
                data_out_q   <= fifo_rdata;
                data_valid_q <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeg_sample_streamer.sv
// Scoreboard bench for eeg_sample_streamer: byte stream in, paced samples out.
// Honours EEG_OFFSET_BINARY_EN in its expected-value model.
module tb_eeg_sample_streamer;
  import preprocessor_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int PL    = 2;
  localparam int SP    = 10;

  logic          clk;
  logic          rst;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          enable;
  logic          flush;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [4:0]    fifo_level;
  logic          underflow;

  int            err_cnt = 0;
  int            chk_cnt = 0;
  int            vcnt = 0;
  int            v0;
  logic          prev_dv = 1'b0;
  logic [DW-1:0] sb[$];

  eeg_sample_streamer #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .PRIME_LEVEL   (PL),
    .SAMPLE_PERIOD (SP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .enable     (enable),
    .flush      (flush),
    .data_out   (data_out),
    .data_valid (data_valid),
    .fifo_level (fifo_level),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] w);
`ifdef EEG_OFFSET_BINARY_EN
    return {~w[DW-1], w[DW-2:0]};
`else
    return w;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst && data_valid) begin
      chk("dv_pulse", 32'(prev_dv), 32'd0);
      if (sb.size() == 0)
        chk("dv_unexpected", 32'd1, 32'd0);
      else
        chk("data", 32'(data_out), 32'(sb.pop_front()));
      vcnt++;
    end
    prev_dv = data_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 1000) begin
      tick(1);
      n++;
    end
    if (!byte_ready) chk("byte_timeout", 32'd1, 32'd0);
    tick(1);
    byte_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] w);
    sb.push_back(model(w));
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!data_valid && n < 300) begin
      tick(1);
      n++;
    end
    chk("dv_timeout", 32'(data_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      tick(1);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    enable     = 1'b0;
    flush      = 1'b0;
    #2;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_uflow", 32'(underflow), 32'd0);
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    chk("ready_up", 32'(byte_ready), 32'd1);

    // basic streaming
    enable = 1'b1;
    tick(2);
    chk("state_prime", 32'(dut.state_q), 32'(PRIME));
    send_sample(16'h1234);
    send_sample(16'h5678);
    wait_valid();
    chk("first_word", 32'(data_out), 32'h1234);
    tick(SP - 1);
    chk("gap_no_dv", 32'(data_valid), 32'd0);
    tick(1);
    chk("second_dv", 32'(data_valid), 32'd1);
    chk("second_word", 32'(data_out), 32'h5678);
    tick(SP - 1);
    chk("uflow_early", 32'(underflow), 32'd0);
    tick(1);
    chk("uflow_set", 32'(underflow), 32'd1);

    // underflow hold
    chk("hold_data", 32'(data_out), 32'h5678);
    chk("hold_state", 32'(dut.state_q), 32'(PRIME));
    v0 = vcnt;
    send_sample(16'h0A0B);
    tick(30);
    chk("hold_no_dv", 32'(vcnt), 32'(v0));
    chk("hold_data2", 32'(data_out), 32'h5678);
    send_sample(16'h0C0D);
    wait_drain();
    tick(25);
    chk("uflow_again", 32'(underflow), 32'd1);

    // flush of a partial sample
    send_byte(8'hAA);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_uflow", 32'(underflow), 32'd0);
    chk("flush_state", 32'(dut.state_q), 32'(PRIME));
    send_sample(16'h0001);
    send_sample(16'hBEEF);
    wait_drain();
    tick(25);

    // backpressure
    enable = 1'b0;
    tick(2);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));
    send_sample(16'h8000);
    send_sample(16'h0000);
    send_sample(16'hFFFF);
    for (int i = 3; i < 16; i++) send_sample(DW'(16'h0101 * i));
    chk("bp_level", 32'(fifo_level), 32'd16);
    chk("bp_ready", 32'(byte_ready), 32'd0);
    fork
      begin
        for (int i = 16; i < 34; i++) send_sample(DW'(16'h1357 + 16'h0203 * i));
      end
      begin
        tick(20);
        chk("stall_ready", 32'(byte_ready), 32'd0);
        chk("stall_level", 32'(fifo_level), 32'd16);
        enable = 1'b1;
        wait_valid();
        chk("ready_after_pop", 32'(byte_ready), 32'd1);
      end
    join
    wait_drain();

    // asynchronous reset mid-stream
    send_sample(16'h1111);
    send_sample(16'h2222);
    send_sample(16'h3333);
    wait_valid();
    tick(3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_dv", 32'(data_valid), 32'd0);
    chk("arst_ready", 32'(byte_ready), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_uflow", 32'(underflow), 32'd0);
    sb.delete();
    tick(2);
    chk("arst_hold", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    v0 = vcnt;
    tick(30);
    chk("post_rst_no_dv", 32'(vcnt), 32'(v0));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
